// File: rtl/wshbn_uart_if.sv
// Wishbone-style slave bus bundle for wshbn_uart.
//   ADR_I  byte address, [3:2] selects the register
//   DAT_I  write data from the master
//   DAT_O  read data to the master (valid during the ACK cycle)
//   WE_I   write enable
//   STB_I  strobe, already address-decoded for this slave
//   CYC_I  bus cycle valid
//   ACK_O  one-cycle transfer acknowledge
interface wshbn_uart_if;
  logic [3:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        WE_I;
  logic        STB_I;
  logic        CYC_I;
  logic        ACK_O;

  modport slave  (input  ADR_I, DAT_I, WE_I, STB_I, CYC_I, output DAT_O, ACK_O);
  modport master (output ADR_I, DAT_I, WE_I, STB_I, CYC_I, input  DAT_O, ACK_O);
endinterface

// File: rtl/wshbn_uart.sv
// wshbn_uart: 8N1 UART with a Wishbone-style register slave.
//   CLK_I, RST_I       sole clock (rising edge) / asynchronous active-high reset
//   bus                slave side of wshbn_uart_if
//   uart_rx, uart_tx   serial in (asynchronous, idle high) / serial out (idle high)
//   uart_full          TX FIFO full
//   uart_empty         no RX byte available
//   interrupt          registered level interrupt
// Registers: 0x0 TXDATA (W), 0x4 RXDATA (R, pops), 0x8 STATUS (R/W1C), 0xC CTRL (R/W).
// Macro WSHBN_UART_RX_FIFO_EN: when defined, received bytes go to an 8-entry
// FIFO; otherwise a single holding register is used.
//
// TX FSM                           RX FSM
// state    | meaning               state    | meaning
// TX_IDLE  | line high, FIFO empty RX_IDLE  | wait for falling edge
// TX_START | start bit (low)       RX_START | half-bit, confirm start low
// TX_DATA  | 8 data bits, LSB 1st  RX_DATA  | sample 8 bits mid-bit
// TX_STOP  | stop bit (high)       RX_STOP  | sample stop bit, store/discard
module wshbn_uart #(
  parameter int CLK_DIV  = 434,
  parameter int TX_DEPTH = 8
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  wshbn_uart_if.slave  bus,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         uart_full,
  output logic         uart_empty,
  output logic         interrupt
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus slave ----------------
  logic       ack_q;
  logic [1:0] reg_sel;
  logic       wr_tx, rd_rx, wr_st, wr_ctrl;
  logic [1:0] ctrl;
  logic [7:0] status;
  logic       rx_empty, rx_full, tx_empty, tx_full, tx_busy;
  logic [7:0] rx_head;
  logic       unused_ok;

  assign reg_sel = bus.ADR_I[3:2];
  assign wr_tx   = ack_q &  bus.WE_I & (reg_sel == 2'd0);
  assign rd_rx   = ack_q & ~bus.WE_I & (reg_sel == 2'd1);
  assign wr_st   = ack_q &  bus.WE_I & (reg_sel == 2'd2);
  assign wr_ctrl = ack_q &  bus.WE_I & (reg_sel == 2'd3);
  assign unused_ok = ^{bus.DAT_I[31:8], bus.ADR_I[1:0]};

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) ack_q <= 1'b0;
    else       ack_q <= bus.CYC_I & bus.STB_I & ~ack_q;

  assign bus.ACK_O = ack_q;

  // Read data is combinational in the ACK cycle so a pop at the end of that
  // cycle always matches the byte the master sees.
  always_comb begin
    bus.DAT_O = '0;
    if (ack_q) begin
      case (reg_sel)
        2'd1:    bus.DAT_O = {24'd0, rx_empty ? 8'd0 : rx_head};
        2'd2:    bus.DAT_O = {24'd0, status};
        2'd3:    bus.DAT_O = {30'd0, ctrl};
        default: bus.DAT_O = '0;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I)        ctrl <= 2'b00;
    else if (wr_ctrl) ctrl <= bus.DAT_I[1:0];

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic        tx_load, tx_push;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = ((tx_wp - tx_rp) == PW'(TX_DEPTH));
  assign tx_push  = wr_tx & (~tx_full | tx_load);

  always_ff @(posedge CLK_I)
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.DAT_I[7:0];

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_load) tx_rp <= tx_rp + PW'(1);
    end

  // ---------------- TX FSM ----------------
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_shift;
  logic        tx_tc;

  assign tx_tc   = (tx_cnt == 16'd0);
  assign tx_load = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_tc));
  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) tx_state <= TX_IDLE;
    else       tx_state <= tx_next;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_tc) tx_next = TX_DATA;
      TX_DATA:  if (tx_tc && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tc) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= tx_mem[tx_rp[AW-1:0]];
      tx_cnt   <= DIV_M1;
      tx_idx   <= '0;
    end else if (tx_state != TX_IDLE) begin
      if (tx_tc) begin
        tx_cnt <= DIV_M1;
        if (tx_state == TX_DATA) begin
          tx_shift <= {1'b1, tx_shift[7:1]};
          tx_idx   <= tx_idx + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt - 16'd1;
      end
    end

  // ---------------- RX synchroniser + FSM ----------------
  logic        rx_m, rx_s, rx_d, rx_fall;
  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_tc, rx_done, rx_req, rx_store, rx_pop;

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) {rx_m, rx_s, rx_d} <= 3'b111;
    else       {rx_m, rx_s, rx_d} <= {uart_rx, rx_m, rx_s};

  assign rx_fall  = rx_d & ~rx_s;
  assign rx_tc    = (rx_cnt == 16'd0);
  assign rx_done  = (rx_state == RX_STOP) & rx_tc;
  assign rx_req   = rx_done & rx_s;
  assign rx_pop   = rd_rx & ~rx_empty;
  assign rx_store = rx_req & (~rx_full | rx_pop);

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tc) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tc) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      if (rx_fall) begin
        rx_cnt <= HALF_M1;
        rx_idx <= '0;
      end
    end else if (rx_tc) begin
      rx_cnt <= DIV_M1;
      if (rx_state == RX_DATA) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_idx   <= rx_idx + 3'd1;
      end
    end else begin
      rx_cnt <= rx_cnt - 16'd1;
    end

  // ---------------- RX storage ----------------
`ifdef WSHBN_UART_RX_FIFO_EN
  logic [7:0] rx_mem [8];
  logic [3:0] rx_wp, rx_rp;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = ((rx_wp - rx_rp) == 4'd8);
  assign rx_head  = rx_mem[rx_rp[2:0]];

  always_ff @(posedge CLK_I)
    if (rx_store) rx_mem[rx_wp[2:0]] <= rx_shift;

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_store) rx_wp <= rx_wp + 4'd1;
      if (rx_pop)   rx_rp <= rx_rp + 4'd1;
    end
`else
  logic [7:0] rx_hold;
  logic       rx_valid;

  assign rx_empty = ~rx_valid;
  assign rx_full  = rx_valid;
  assign rx_head  = rx_hold;

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      rx_hold  <= '0;
      rx_valid <= 1'b0;
    end else if (rx_store) begin
      rx_hold  <= rx_shift;
      rx_valid <= 1'b1;
    end else if (rx_pop) begin
      rx_valid <= 1'b0;
    end
`endif

  // ---------------- status, interrupt ----------------
  logic rx_ovr, frame_err, tx_ovr;

  // A set in the same cycle as a W1C wins so no event is lost.
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovr    <= 1'b0;
    end else begin
      if (rx_req & rx_full & ~rx_pop)       rx_ovr <= 1'b1;
      else if (wr_st & bus.DAT_I[5])        rx_ovr <= 1'b0;
      if (rx_done & ~rx_s)                  frame_err <= 1'b1;
      else if (wr_st & bus.DAT_I[6])        frame_err <= 1'b0;
      if (wr_tx & tx_full & ~tx_load)       tx_ovr <= 1'b1;
      else if (wr_st & bus.DAT_I[7])        tx_ovr <= 1'b0;
    end

  assign status = {tx_ovr, frame_err, rx_ovr, tx_busy, rx_full, rx_empty, tx_empty, tx_full};

  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) interrupt <= 1'b0;
    else       interrupt <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);

  assign uart_full  = tx_full;
  assign uart_empty = rx_empty;
endmodule

// File: tb/tb_wshbn_uart.sv
// Directed bench for wshbn_uart: two instances, CLK_DIV=4 (TX paths) and
// CLK_DIV=8 (RX paths), sharing one bus driver selected by 'sel'.
module tb_wshbn_uart;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        sel = 1'b0;
  logic        rx4 = 1'b1, rx8 = 1'b1;
  logic        tx4, tx8, full4, full8, empty4, empty8, irq4, irq8;
  logic        ack;
  logic [31:0] rdat;

  wshbn_uart_if bus4();
  wshbn_uart_if bus8();

  assign bus4.ADR_I = adr;  assign bus8.ADR_I = adr;
  assign bus4.DAT_I = wdat; assign bus8.DAT_I = wdat;
  assign bus4.WE_I  = we;   assign bus8.WE_I  = we;
  assign bus4.CYC_I = cyc;  assign bus8.CYC_I = cyc;
  assign bus4.STB_I = stb & ~sel;
  assign bus8.STB_I = stb &  sel;
  assign ack  = sel ? bus8.ACK_O : bus4.ACK_O;
  assign rdat = sel ? bus8.DAT_O : bus4.DAT_O;

  wshbn_uart #(.CLK_DIV(4), .TX_DEPTH(8)) u_dut4 (
    .CLK_I(clk), .RST_I(rst), .bus(bus4), .uart_rx(rx4), .uart_tx(tx4),
    .uart_full(full4), .uart_empty(empty4), .interrupt(irq4));

  wshbn_uart #(.CLK_DIV(8), .TX_DEPTH(8)) u_dut8 (
    .CLK_I(clk), .RST_I(rst), .bus(bus8), .uart_rx(rx8), .uart_tx(tx8),
    .uart_full(full8), .uart_empty(empty8), .interrupt(irq8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    adr = a; wdat = d; we = wr; cyc = 1'b1; stb = 1'b1;
    n = 0;
    q = '0;
    while (ack !== 1'b1 && n < 8) begin
      tick(1);
      n++;
    end
    check("ack_latency", 64'(n), 64'd1);
    if (ack === 1'b1) q = rdat;
    tick(1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_one_cycle", 64'(ack), 64'd0);
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus_xfer(1'b1, a, d, q);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] q);
    bus_xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic expect_rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus_rd(a, q);
    check(tag, 64'(q), 64'(exp));
  endtask

  // Decode one frame from tx4 (CLK_DIV=4); gap = cycles waited for the start edge.
  task automatic decode4(output logic [7:0] b, output int gap);
    gap = 0;
    b = '0;
    while (tx4 !== 1'b0 && gap < 200) begin
      tick(1);
      gap++;
    end
    if (tx4 !== 1'b0) check("tx_start_timeout", 64'(tx4), 64'd0);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      tick(4);
      b[i] = tx4;
    end
    tick(4);
    check("tx_stop_bit", 64'(tx4), 64'd1);
  endtask

  task automatic send8(input logic [7:0] b, input logic stop);
    rx8 = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rx8 = b[i];
      tick(8);
    end
    rx8 = stop;
    tick(8);
    rx8 = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [43:0] obs, exp_v;
    logic [9:0]  fr;
    logic [7:0]  b;
    logic [31:0] q;
    int          w;

    // ---- reset state ----
    tick(3);
    check("rst_tx", 64'(tx4), 64'd1);
    check("rst_full", 64'(full4), 64'd0);
    check("rst_empty", 64'(empty8), 64'd1);
    check("rst_irq", 64'({irq4, irq8}), 64'd0);
    check("rst_ack", 64'({bus4.ACK_O, bus8.ACK_O}), 64'd0);
    check("rst_dato", 64'(bus4.DAT_O), 64'd0);
    rst = 1'b0;
    tick(2);
    sel = 1'b0;
    expect_rd("status_after_rst", 4'h8, 32'h06);
    expect_rd("ctrl_after_rst", 4'hC, 32'h0);
    expect_rd("txdata_reads_0", 4'h0, 32'h0);

    // ---- single 0xA5 frame, 4 cycles per bit ----
    bus_wr(4'h0, 32'h0000_00A5);
    w = 0;
    while (tx4 !== 1'b0 && w < 50) begin tick(1); w++; end
    check("a5_start_seen", 64'(tx4), 64'd0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 44; k++) begin
      if (k > 0) tick(1);
      obs[k]   = tx4;
      exp_v[k] = (k < 40) ? fr[k / 4] : 1'b1;
    end
    check("a5_waveform", 64'(obs), 64'(exp_v));
    expect_rd("a5_status_idle", 4'h8, 32'h06);

    // ---- TX overrun while a frame is in flight ----
    bus_wr(4'h0, 32'hFF);
    w = 0;
    while (tx4 !== 1'b0 && w < 50) begin tick(1); w++; end
    for (int i = 0; i < 9; i++) bus_wr(4'h0, 32'h20 + i);
    check("ovr_uart_full", 64'(full4), 64'd1);
    expect_rd("ovr_status", 4'h8, 32'h95);
    bus_wr(4'h8, 32'h80);
    expect_rd("ovr_cleared", 4'h8, 32'h15);
    for (int i = 0; i < 8; i++) begin
      decode4(b, w);
      check($sformatf("drain_byte%0d", i), 64'(b), 64'(8'h20 + i));
      if (i > 0) check($sformatf("b2b_gap%0d", i), 64'(w), 64'd2);
    end
    tick(10);
    expect_rd("drain_status", 4'h8, 32'h06);

    // ---- RX byte 0x3C ----
    sel = 1'b1;
    check("rx_empty_before", 64'(empty8), 64'd1);
    send8(8'h3C, 1'b1);
    tick(2);
    check("rx_empty_falls", 64'(empty8), 64'd0);
    expect_rd("rx_3c", 4'h4, 32'h0000_003C);
    check("rx_empty_rises", 64'(empty8), 64'd1);
    expect_rd("rx_empty_read", 4'h4, 32'h0);

    // ---- glitch rejection and framing error ----
    rx8 = 1'b0;
    tick(2);
    rx8 = 1'b1;
    tick(20);
    check("glitch_empty", 64'(empty8), 64'd1);
    expect_rd("glitch_status", 4'h8, 32'h06);
    send8(8'hA5, 1'b0);
    tick(16);
    check("ferr_empty", 64'(empty8), 64'd1);
    expect_rd("ferr_status", 4'h8, 32'h46);
    bus_wr(4'h8, 32'h40);
    expect_rd("ferr_cleared", 4'h8, 32'h06);

    // ---- RX interrupt ----
    bus_wr(4'hC, 32'h1);
    expect_rd("ctrl_rb", 4'hC, 32'h1);
    tick(2);
    check("irq_idle", 64'(irq8), 64'd0);
    send8(8'h55, 1'b1);
    tick(4);
    check("irq_rx_high", 64'(irq8), 64'd1);
    tick(10);
    check("irq_rx_held", 64'(irq8), 64'd1);
    expect_rd("irq_rx_data", 4'h4, 32'h55);
    tick(2);
    check("irq_rx_low", 64'(irq8), 64'd0);
    bus_wr(4'hC, 32'h2);
    tick(2);
    check("irq_tx_idle", 64'(irq8), 64'd1);
    bus_wr(4'hC, 32'h0);
    tick(2);
    check("irq_off", 64'(irq8), 64'd0);

    // ---- RX storage overflow ----
`ifdef WSHBN_UART_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) send8(8'(i), 1'b1);
    tick(4);
    expect_rd("rxovr_status", 4'h8, 32'h2A);
    for (int i = 1; i <= 8; i++) expect_rd($sformatf("rxovr_byte%0d", i), 4'h4, 32'(i));
    expect_rd("rxovr_ninth_gone", 4'h4, 32'h0);
`else
    send8(8'h01, 1'b1);
    send8(8'h02, 1'b1);
    tick(4);
    expect_rd("rxovr_status", 4'h8, 32'h2A);
    expect_rd("rxovr_first", 4'h4, 32'h01);
    expect_rd("rxovr_second_gone", 4'h4, 32'h0);
`endif
    bus_wr(4'h8, 32'h20);
    expect_rd("rxovr_cleared", 4'h8, 32'h06);

    // ---- reset in the middle of a TX frame ----
    sel = 1'b0;
    bus_wr(4'h0, 32'h00);
    w = 0;
    while (tx4 !== 1'b0 && w < 50) begin tick(1); w++; end
    tick(10);
    adr = 4'h8; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    tick(1);
    check("midtx_ack_before", 64'(ack), 64'd1);
    check("midtx_tx_low", 64'(tx4), 64'd0);
    rst = 1'b1;
    #1;
    check("midtx_tx_high", 64'(tx4), 64'd1);
    check("midtx_ack_low", 64'(ack), 64'd0);
    check("midtx_dato_0", 64'(rdat), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    expect_rd("midtx_status", 4'h8, 32'h06);
    tick(20);
    check("midtx_tx_stays_high", 64'(tx4), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
